fwd_hazard_unit: RTL and testbench

Parametrised successor to the two-stage forwarding unit.
- Forwards operands to EX from NUM_STAGES pipeline stages plus the long-latency unit (LU: divider/multi-cycle ops) writeback port, with strict youngest-first priority.
- Keeps a registered scoreboard of LU destinations in flight.
- Generates the ID/EX stall for load-use, RAW-on-pending and WAW-on-pending hazards, and for an LU that is at its occupancy limit.
- Sits beside the pipeline control and drives EX operand muxes and the stall to PC/IF/ID.

---
 rtl/fwd_hazard_unit.sv | 138 +++++++++++++
 tb/tb_fwd_hazard_unit.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// EX operand forwarding from NUM_STAGES pipeline stages plus the long-latency
// unit writeback, with a scoreboard of in-flight LU destinations and ID/EX stall.
module fwd_hazard_unit #(
  parameter int XLEN       = 32,
  parameter int NUM_STAGES = 2,
  parameter int MAX_LONG   = 4,
  parameter int CNT_W      = 16,
  localparam int LCW       = $clog2(MAX_LONG + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [4:0]                 ID_rs1,
  input  logic [4:0]                 ID_rs2,
  input  logic [4:0]                 ID_rd,
  input  logic [2:0]                 ID_ValidReg,
  input  logic                       ID_long,
  input  logic                       ID_issue,
  input  logic [4:0]                 EX_rs1,
  input  logic [4:0]                 EX_rs2,
  input  logic [2:0]                 EX_ValidReg,
  input  logic [5*NUM_STAGES-1:0]    ST_rd,
  input  logic [NUM_STAGES-1:0]      ST_wen,
  input  logic [NUM_STAGES-1:0]      ST_ready,
  input  logic [XLEN*NUM_STAGES-1:0] ST_data,
  input  logic                       LU_done,
  input  logic [4:0]                 LU_rd,
  input  logic [XLEN-1:0]            LU_data,
  input  logic                       LU_flush,
  output logic                       rs1_fwd,
  output logic                       rs2_fwd,
  output logic [XLEN-1:0]            rs1_fwd_data,
  output logic [XLEN-1:0]            rs2_fwd_data,
  output logic                       stall,
  output logic [31:0]                pending,
  output logic [LCW-1:0]             lu_count,
  output logic [CNT_W-1:0]           stall_cycles
);

  typedef struct packed {
    logic            fwd;
    logic            not_ready;
    logic [XLEN-1:0] data;
  } fwd_t;

  logic [31:0]      r_pending;
  logic [LCW-1:0]   r_lu_count;
  logic [CNT_W-1:0] r_stall_cycles;
  logic [31:0]      w_pending_nxt;
  logic [LCW-1:0]   w_lu_count_nxt;
  fwd_t             w_sel1;
  fwd_t             w_sel2;
  logic             w_raw1;
  logic             w_raw2;
  logic             w_waw;
  logic             w_full;
  logic             w_lu_inc;
  logic             w_lu_dec;

  // Oldest stage is visited first so a younger match overwrites it; the LU
  // result is the lowest-priority fallback.
  function automatic fwd_t fwd_sel(input logic vr, input logic [4:0] rs);
    fwd_t r;
    r = '0;
    if (rs != 5'd0) begin
      if (LU_done && LU_rd == rs) begin
        r.fwd  = 1'b1;
        r.data = LU_data;
      end
      for (int i = NUM_STAGES - 1; i >= 0; i--) begin
        if (vr && ST_wen[i] && ST_rd[5*i +: 5] == rs) begin
          r.fwd       = 1'b1;
          r.not_ready = !ST_ready[i];
          r.data      = ST_data[XLEN*i +: XLEN];
        end
      end
    end
    return r;
  endfunction

  assign w_sel1       = fwd_sel(EX_ValidReg[1], EX_rs1);
  assign w_sel2       = fwd_sel(EX_ValidReg[2], EX_rs2);
  assign rs1_fwd      = w_sel1.fwd;
  assign rs2_fwd      = w_sel2.fwd;
  assign rs1_fwd_data = w_sel1.data;
  assign rs2_fwd_data = w_sel2.data;

  // An LU result arriving this cycle resolves the RAW dependency via forwarding.
  assign w_raw1 = ID_ValidReg[1] && ID_rs1 != 5'd0 && r_pending[ID_rs1]
                  && !(LU_done && LU_rd == ID_rs1);
  assign w_raw2 = ID_ValidReg[2] && ID_rs2 != 5'd0 && r_pending[ID_rs2]
                  && !(LU_done && LU_rd == ID_rs2);
  assign w_waw  = ID_ValidReg[0] && ID_rd != 5'd0 && r_pending[ID_rd];
  assign w_full = ID_long && r_lu_count == LCW'(MAX_LONG) && !LU_done;
  assign stall  = w_sel1.not_ready || w_sel2.not_ready || w_raw1 || w_raw2
                  || w_waw || w_full;

  assign w_lu_inc = ID_issue && ID_long;
  assign w_lu_dec = LU_done && r_lu_count != '0;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_pending_nxt  = r_pending;
    w_lu_count_nxt = r_lu_count;
    if (LU_flush) begin
      w_pending_nxt  = '0;
      w_lu_count_nxt = '0;
    end else begin
      if (LU_done)
        w_pending_nxt[LU_rd] = 1'b0;
      if (w_lu_inc && ID_ValidReg[0] && ID_rd != 5'd0)
        w_pending_nxt[ID_rd] = 1'b1;
      if (w_lu_inc && !w_lu_dec && r_lu_count < LCW'(MAX_LONG))
        w_lu_count_nxt = r_lu_count + LCW'(1);
      else if (w_lu_dec && !w_lu_inc)
        w_lu_count_nxt = r_lu_count - LCW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending      <= '0;
      r_lu_count     <= '0;
      r_stall_cycles <= '0;
    end else begin
      r_pending  <= w_pending_nxt;
      r_lu_count <= w_lu_count_nxt;
      if (stall && r_stall_cycles != '1)
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
    end
  end

  assign pending      = r_pending;
  assign lu_count     = r_lu_count;
  assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed self-checking bench for fwd_hazard_unit: forwarding priority,
// load-use, LU scoreboard, WAW, capacity, flush, async reset, counter saturation.
module tb_fwd_hazard_unit;

  localparam int XLEN  = 32;
  localparam int NS    = 2;
  localparam int ML    = 4;
  localparam int CNT_W = 4;
  localparam int LCW   = $clog2(ML + 1);

  logic            clk = 1'b0;
  logic            rst_n;
  logic [4:0]      ID_rs1, ID_rs2, ID_rd;
  logic [2:0]      ID_ValidReg;
  logic            ID_long, ID_issue;
  logic [4:0]      EX_rs1, EX_rs2;
  logic [2:0]      EX_ValidReg;
  logic [5*NS-1:0] ST_rd;
  logic [NS-1:0]   ST_wen, ST_ready;
  logic [XLEN*NS-1:0] ST_data;
  logic            LU_done;
  logic [4:0]      LU_rd;
  logic [XLEN-1:0] LU_data;
  logic            LU_flush;
  logic            rs1_fwd, rs2_fwd, stall;
  logic [XLEN-1:0] rs1_fwd_data, rs2_fwd_data;
  logic [31:0]     pending;
  logic [LCW-1:0]  lu_count;
  logic [CNT_W-1:0] stall_cycles;

  int checks = 0;
  int errors = 0;
  int exp_sc = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.XLEN(XLEN), .NUM_STAGES(NS), .MAX_LONG(ML), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_rd(ID_rd), .ID_ValidReg(ID_ValidReg),
    .ID_long(ID_long), .ID_issue(ID_issue),
    .EX_rs1(EX_rs1), .EX_rs2(EX_rs2), .EX_ValidReg(EX_ValidReg),
    .ST_rd(ST_rd), .ST_wen(ST_wen), .ST_ready(ST_ready), .ST_data(ST_data),
    .LU_done(LU_done), .LU_rd(LU_rd), .LU_data(LU_data), .LU_flush(LU_flush),
    .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd),
    .rs1_fwd_data(rs1_fwd_data), .rs2_fwd_data(rs2_fwd_data),
    .stall(stall), .pending(pending), .lu_count(lu_count), .stall_cycles(stall_cycles)
  );

  task automatic idle();
    ID_rs1 = 0; ID_rs2 = 0; ID_rd = 0; ID_ValidReg = 0; ID_long = 0; ID_issue = 0;
    EX_rs1 = 0; EX_rs2 = 0; EX_ValidReg = 0;
    ST_rd = 0; ST_wen = 0; ST_ready = '1; ST_data = 0;
    LU_done = 0; LU_rd = 0; LU_data = 0; LU_flush = 0;
  endtask

  task automatic edge_();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    #12;
    checks++;
    if (pending !== 32'd0 || lu_count !== 0 || stall_cycles !== 0) begin
      errors++;
      $display("FAIL reset_state: pending=%h lu_count=%0d stall_cycles=%0d, want 0/0/0",
               pending, lu_count, stall_cycles);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_fwd_priority();
    @(negedge clk);
    ST_rd = {5'd5, 5'd5}; ST_wen = 2'b11; ST_ready = 2'b11;
    ST_data = {32'h22, 32'h11};
    EX_ValidReg = 3'b010; EX_rs1 = 5'd5; EX_rs2 = 5'd5;
    #1; checks++;
    if (rs1_fwd !== 1'b1 || rs1_fwd_data !== 32'h11) begin
      errors++; $display("FAIL fwd_youngest: fwd=%b data=%h, want 1/00000011", rs1_fwd, rs1_fwd_data);
    end
    checks++;
    if (rs2_fwd !== 1'b0 || rs2_fwd_data !== 32'h0) begin
      errors++; $display("FAIL fwd_rs2_not_read: fwd=%b data=%h, want 0/0", rs2_fwd, rs2_fwd_data);
    end
    ST_wen = 2'b10;
    #1; checks++;
    if (rs1_fwd !== 1'b1 || rs1_fwd_data !== 32'h22) begin
      errors++; $display("FAIL fwd_wb: fwd=%b data=%h, want 1/00000022", rs1_fwd, rs1_fwd_data);
    end
    ST_wen = 2'b00; LU_done = 1'b1; LU_rd = 5'd5; LU_data = 32'h55;
    #1; checks++;
    if (rs1_fwd !== 1'b1 || rs1_fwd_data !== 32'h55) begin
      errors++; $display("FAIL fwd_lu_fallback: fwd=%b data=%h, want 1/00000055", rs1_fwd, rs1_fwd_data);
    end
    ST_wen = 2'b01;
    #1; checks++;
    if (rs1_fwd_data !== 32'h11) begin
      errors++; $display("FAIL fwd_stage_over_lu: data=%h, want 00000011", rs1_fwd_data);
    end
    LU_done = 1'b0; ST_rd = 10'd0; ST_wen = 2'b11; EX_rs1 = 5'd0;
    #1; checks++;
    if (rs1_fwd !== 1'b0 || rs1_fwd_data !== 32'h0 || stall !== 1'b0) begin
      errors++; $display("FAIL fwd_x0: fwd=%b data=%h stall=%b, want 0/0/0", rs1_fwd, rs1_fwd_data, stall);
    end
    idle();
  endtask

  task automatic test_load_use();
    @(negedge clk);
    ST_rd = {5'd7, 5'd7}; ST_wen = 2'b11; ST_ready = 2'b10;
    ST_data = {32'hB0, 32'hA0};
    EX_ValidReg = 3'b100; EX_rs2 = 5'd7;
    #1; checks++;
    if (stall !== 1'b1 || rs2_fwd !== 1'b1 || rs2_fwd_data !== 32'hA0) begin
      errors++; $display("FAIL load_use_stall: stall=%b fwd=%b data=%h, want 1/1/000000a0",
                         stall, rs2_fwd, rs2_fwd_data);
    end
    for (int c = 0; c < 2; c++) begin
      edge_(); exp_sc++;
      checks++;
      if (stall_cycles !== CNT_W'(exp_sc)) begin
        errors++; $display("FAIL load_use_count: stall_cycles=%0d, want %0d", stall_cycles, exp_sc);
      end
    end
    @(negedge clk); ST_ready = 2'b11;
    #1; checks++;
    if (stall !== 1'b0 || rs2_fwd_data !== 32'hA0) begin
      errors++; $display("FAIL load_use_ready: stall=%b data=%h, want 0/000000a0", stall, rs2_fwd_data);
    end
    edge_(); checks++;
    if (stall_cycles !== CNT_W'(exp_sc)) begin
      errors++; $display("FAIL load_use_hold: stall_cycles=%0d, want %0d", stall_cycles, exp_sc);
    end
    @(negedge clk); idle();
  endtask

  task automatic test_lu_raw();
    ID_issue = 1; ID_long = 1; ID_ValidReg = 3'b001; ID_rd = 5'd9;
    edge_(); checks++;
    if (pending !== 32'h200 || lu_count !== 1) begin
      errors++; $display("FAIL lu_issue: pending=%h lu_count=%0d, want 00000200/1", pending, lu_count);
    end
    @(negedge clk); idle(); ID_ValidReg = 3'b010; ID_rs1 = 5'd9;
    #1; checks++;
    if (stall !== 1'b1) begin
      errors++; $display("FAIL raw_stall: stall=%b, want 1", stall);
    end
    edge_(); exp_sc++;
    @(negedge clk);
    LU_done = 1; LU_rd = 5'd9; LU_data = 32'hDEAD; EX_ValidReg = 3'b010; EX_rs1 = 5'd9;
    #1; checks++;
    if (rs1_fwd_data !== 32'hDEAD || stall !== 1'b0) begin
      errors++; $display("FAIL lu_done_fwd: data=%h stall=%b, want 0000dead/0", rs1_fwd_data, stall);
    end
    edge_(); checks++;
    if (pending !== 32'h0 || lu_count !== 0 || stall_cycles !== CNT_W'(exp_sc)) begin
      errors++; $display("FAIL lu_retire: pending=%h lu_count=%0d sc=%0d, want 0/0/%0d",
                         pending, lu_count, stall_cycles, exp_sc);
    end
    @(negedge clk); idle();
  endtask

  task automatic test_waw();
    ID_issue = 1; ID_long = 1; ID_ValidReg = 3'b001; ID_rd = 5'd3;
    edge_();
    @(negedge clk); ID_issue = 0; ID_long = 0;
    #1; checks++;
    if (stall !== 1'b1) begin
      errors++; $display("FAIL waw_stall: stall=%b, want 1", stall);
    end
    edge_(); exp_sc++;
    @(negedge clk); ID_issue = 1; ID_long = 1; LU_done = 1; LU_rd = 5'd3;
    edge_(); exp_sc++;
    checks++;
    if (pending !== 32'h8 || lu_count !== 1) begin
      errors++; $display("FAIL set_wins: pending=%h lu_count=%0d, want 00000008/1", pending, lu_count);
    end
    @(negedge clk); idle(); LU_done = 1; LU_rd = 5'd3;
    edge_(); checks++;
    if (pending !== 32'h0 || lu_count !== 0 || stall_cycles !== CNT_W'(exp_sc)) begin
      errors++; $display("FAIL waw_clear: pending=%h lu_count=%0d sc=%0d, want 0/0/%0d",
                         pending, lu_count, stall_cycles, exp_sc);
    end
    @(negedge clk); idle();
  endtask

  task automatic test_capacity();
    for (int k = 0; k < ML; k++) begin
      ID_issue = 1; ID_long = 1; ID_ValidReg = 3'b001; ID_rd = 5'(10 + k);
      edge_();
      @(negedge clk);
    end
    idle(); ID_long = 1;
    #1; checks++;
    if (lu_count !== LCW'(ML) || stall !== 1'b1) begin
      errors++; $display("FAIL capacity_stall: lu_count=%0d stall=%b, want %0d/1", lu_count, stall, ML);
    end
    LU_done = 1; LU_rd = 5'd10;
    #1; checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL capacity_done: stall=%b, want 0", stall);
    end
    edge_(); checks++;
    if (lu_count !== 3 || pending !== 32'h3800) begin
      errors++; $display("FAIL capacity_retire: lu_count=%0d pending=%h, want 3/00003800", lu_count, pending);
    end
    @(negedge clk); idle();
  endtask

  task automatic test_flush();
    LU_flush = 1; ID_issue = 1; ID_long = 1; ID_ValidReg = 3'b001; ID_rd = 5'd20;
    LU_done = 1; LU_rd = 5'd11;
    edge_(); checks++;
    if (pending !== 32'h0 || lu_count !== 0 || stall_cycles !== CNT_W'(exp_sc)) begin
      errors++; $display("FAIL flush: pending=%h lu_count=%0d sc=%0d, want 0/0/%0d",
                         pending, lu_count, stall_cycles, exp_sc);
    end
    @(negedge clk); idle();
  endtask

  task automatic test_async_reset();
    ID_issue = 1; ID_long = 1; ID_ValidReg = 3'b001; ID_rd = 5'd6;
    edge_();
    @(negedge clk); idle(); ID_ValidReg = 3'b100; ID_rs2 = 5'd6;
    edge_(); exp_sc++;
    checks++;
    if (pending !== 32'h40 || lu_count !== 1 || stall_cycles !== CNT_W'(exp_sc)) begin
      errors++; $display("FAIL pre_reset: pending=%h lu_count=%0d sc=%0d, want 00000040/1/%0d",
                         pending, lu_count, stall_cycles, exp_sc);
    end
    #1 rst_n = 1'b0;
    #1; checks++;
    if (pending !== 32'h0 || lu_count !== 0 || stall_cycles !== 0) begin
      errors++; $display("FAIL async_reset: pending=%h lu_count=%0d sc=%0d, want 0/0/0",
                         pending, lu_count, stall_cycles);
    end
    exp_sc = 0;
    @(negedge clk); idle(); rst_n = 1'b1;
  endtask

  task automatic test_saturation();
    ST_rd = {5'd0, 5'd8}; ST_wen = 2'b01; ST_ready = 2'b10;
    EX_ValidReg = 3'b010; EX_rs1 = 5'd8;
    repeat (20) edge_();
    checks++;
    if (stall_cycles !== {CNT_W{1'b1}}) begin
      errors++; $display("FAIL saturate: stall_cycles=%0d, want %0d", stall_cycles, (1 << CNT_W) - 1);
    end
    @(negedge clk); idle();
  endtask

  initial begin
    test_reset();
    test_fwd_priority();
    test_load_use();
    test_lu_raw();
    test_waw();
    test_capacity();
    test_flush();
    test_async_reset();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
